// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: operand-mux select codes, forwarding FSM states
// and the default register-address width.
package pipe_pkg;

  localparam int DEF_REG_AW = 5;

  localparam logic [1:0] SEL_RF    = 2'd0;
  localparam logic [1:0] SEL_EXMEM = 2'd1;
  localparam logic [1:0] SEL_MEMWB = 2'd2;
  localparam logic [1:0] SEL_IMM   = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_HOLD     = 2'd2
  } fwd_state_t;

endpackage

// File: rtl/fwd_match.sv
// Compares one ID source register against the EX and MEM destinations.
// Register 0 is hardwired, so it never matches a producer.
module fwd_match
  import pipe_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_we,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_we,
  output logic              hit_ex,
  output logic              hit_mem
);

  logic src_nonzero;

  assign src_nonzero = (src != '0);
  assign hit_ex      = ex_we  & (ex_rd  == src) & src_nonzero;
  assign hit_mem     = mem_we & (mem_rd == src) & src_nonzero;

endmodule

// File: rtl/fwd_sel_ctrl.sv
// ID-stage forwarding control: computes registered ALU operand mux selects,
// inserts a one-cycle load-use stall plus bubble, and honours pipeline hold.
module fwd_sel_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hold_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs_i,
  input  logic [REG_AW-1:0] id_rt_i,
  input  logic              id_use_rs_i,
  input  logic              id_use_rt_i,
  input  logic              id_use_imm_i,
  input  logic [REG_AW-1:0] ex_rd_i,
  input  logic              ex_we_i,
  input  logic              ex_load_i,
  input  logic [REG_AW-1:0] mem_rd_i,
  input  logic              mem_we_i,
  output logic              stall_o,
  output logic              bubble_o,
  output logic [1:0]        sel_a_o,
  output logic [1:0]        sel_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  fwd_state_t state, state_next;

  logic       hit_ex_rs, hit_mem_rs, hit_ex_rt, hit_mem_rt;
  logic       lu;
  logic       do_load, do_bubble;
  logic [1:0] sel_a_c, sel_b_c;

  fwd_match #(.REG_AW(REG_AW)) u_match_rs (
    .src     (id_rs_i),
    .ex_rd   (ex_rd_i),
    .ex_we   (ex_we_i),
    .mem_rd  (mem_rd_i),
    .mem_we  (mem_we_i),
    .hit_ex  (hit_ex_rs),
    .hit_mem (hit_mem_rs)
  );

  fwd_match #(.REG_AW(REG_AW)) u_match_rt (
    .src     (id_rt_i),
    .ex_rd   (ex_rd_i),
    .ex_we   (ex_we_i),
    .mem_rd  (mem_rd_i),
    .mem_we  (mem_we_i),
    .hit_ex  (hit_ex_rt),
    .hit_mem (hit_mem_rt)
  );

  // EX match is checked first because it is the youngest producer
  always_comb begin
    sel_a_c = SEL_RF;
    sel_b_c = SEL_RF;
    if (id_use_rs_i) begin
      if (hit_ex_rs)       sel_a_c = SEL_EXMEM;
      else if (hit_mem_rs) sel_a_c = SEL_MEMWB;
    end
    if (id_use_imm_i) begin
      sel_b_c = SEL_IMM;
    end else if (id_use_rt_i) begin
      if (hit_ex_rt)       sel_b_c = SEL_EXMEM;
      else if (hit_mem_rt) sel_b_c = SEL_MEMWB;
    end
  end

  assign lu = id_valid_i & ex_load_i &
              ((id_use_rs_i & hit_ex_rs) | (id_use_rt_i & ~id_use_imm_i & hit_ex_rt));

  // A released hold makes its decision in the same cycle, exactly like RUN
  always_comb begin
    state_next = state;
    stall_o    = 1'b0;
    do_load    = 1'b0;
    do_bubble  = 1'b0;
    case (state)
      ST_RUN, ST_HOLD: begin
        if (hold_i) begin
          state_next = ST_HOLD;
          stall_o    = 1'b1;
        end else if (lu) begin
          state_next = ST_LU_STALL;
          stall_o    = 1'b1;
          do_bubble  = 1'b1;
        end else begin
          state_next = ST_RUN;
          do_load    = 1'b1;
        end
      end
      ST_LU_STALL: begin
        if (hold_i) begin
          state_next = ST_HOLD;
        end else begin
          state_next = ST_RUN;
          do_load    = 1'b1;
        end
      end
      default: state_next = ST_RUN;
    endcase
    if (rst) stall_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      bubble_o    <= 1'b1;
      sel_a_o     <= SEL_RF;
      sel_b_o     <= SEL_RF;
      stall_cnt_o <= '0;
    end else begin
      state <= state_next;
      if (do_load) begin
        bubble_o <= ~id_valid_i;
        sel_a_o  <= sel_a_c;
        sel_b_o  <= sel_b_c;
      end else if (do_bubble) begin
        bubble_o <= 1'b1;
        sel_a_o  <= SEL_RF;
        sel_b_o  <= SEL_RF;
        if (stall_cnt_o != '1) stall_cnt_o <= stall_cnt_o + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Cycle-by-cycle vector table for fwd_sel_ctrl; registered outputs are queued
// when a row is driven and compared after the following clock edge.
module tb_fwd_sel_ctrl;

  typedef struct packed {
    logic        rst, hold, valid;
    logic [4:0]  rs, rt;
    logic        urs, urt, uimm;
    logic [4:0]  exrd;
    logic        exwe, exld;
    logic [4:0]  memrd;
    logic        memwe;
    logic        xstall, xbub;
    logic [1:0]  xsa, xsb;
    logic [15:0] xcnt;
    logic [1:0]  xcnts;
  } vec_t;

  typedef struct packed {
    logic        xbub;
    logic [1:0]  xsa, xsb;
    logic [15:0] xcnt;
    logic [1:0]  xcnts;
    int          row;
  } exp_t;

  logic        clk;
  logic        rst, hold, valid, urs, urt, uimm, exwe, exld, memwe;
  logic [4:0]  rs, rt, exrd, memrd;
  logic        stall, bubble, stall_s, bubble_s;
  logic [1:0]  sel_a, sel_b, sel_a_s, sel_b_s;
  logic [15:0] cnt;
  logic [1:0]  cnt_s;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  fwd_sel_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .hold_i(hold), .id_valid_i(valid),
    .id_rs_i(rs), .id_rt_i(rt), .id_use_rs_i(urs), .id_use_rt_i(urt),
    .id_use_imm_i(uimm), .ex_rd_i(exrd), .ex_we_i(exwe), .ex_load_i(exld),
    .mem_rd_i(memrd), .mem_we_i(memwe), .stall_o(stall), .bubble_o(bubble),
    .sel_a_o(sel_a), .sel_b_o(sel_b), .stall_cnt_o(cnt)
  );

  // Narrow-counter copy driven by the same stimulus, for saturation
  fwd_sel_ctrl #(.REG_AW(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .hold_i(hold), .id_valid_i(valid),
    .id_rs_i(rs), .id_rt_i(rt), .id_use_rs_i(urs), .id_use_rt_i(urt),
    .id_use_imm_i(uimm), .ex_rd_i(exrd), .ex_we_i(exwe), .ex_load_i(exld),
    .mem_rd_i(memrd), .mem_we_i(memwe), .stall_o(stall_s), .bubble_o(bubble_s),
    .sel_a_o(sel_a_s), .sel_b_o(sel_b_s), .stall_cnt_o(cnt_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(
    input logic r, h, v, input logic [4:0] a, b,
    input logic ua, ub, ui, input logic [4:0] er, input logic ew, el,
    input logic [4:0] mr, input logic mw,
    input logic xs, xb, input logic [1:0] xa, xbsel,
    input logic [15:0] xc, input logic [1:0] xcs);
    vec_t t;
    t = '{rst:r, hold:h, valid:v, rs:a, rt:b, urs:ua, urt:ub, uimm:ui,
          exrd:er, exwe:ew, exld:el, memrd:mr, memwe:mw,
          xstall:xs, xbub:xb, xsa:xa, xsb:xbsel, xcnt:xc, xcnts:xcs};
    vecs.push_back(t);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] act,
                             input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int row);
    exp_t e;
    exp_t g;
    @(negedge clk);
    rst = v.rst; hold = v.hold; valid = v.valid;
    rs = v.rs; rt = v.rt; urs = v.urs; urt = v.urt; uimm = v.uimm;
    exrd = v.exrd; exwe = v.exwe; exld = v.exld; memrd = v.memrd; memwe = v.memwe;
    #1;
    checkOutput($sformatf("row%0d_stall", row), 16'(stall), 16'(v.xstall));
    checkOutput($sformatf("row%0d_stall_sat", row), 16'(stall_s), 16'(v.xstall));
    e = '{xbub:v.xbub, xsa:v.xsa, xsb:v.xsb, xcnt:v.xcnt, xcnts:v.xcnts, row:row};
    sb.push_back(e);
    @(posedge clk);
    #1;
    g = sb.pop_front();
    checkOutput($sformatf("row%0d_bubble", g.row), 16'(bubble), 16'(g.xbub));
    checkOutput($sformatf("row%0d_sel_a", g.row), 16'(sel_a), 16'(g.xsa));
    checkOutput($sformatf("row%0d_sel_b", g.row), 16'(sel_b), 16'(g.xsb));
    checkOutput($sformatf("row%0d_cnt", g.row), cnt, g.xcnt);
    checkOutput($sformatf("row%0d_cnt_sat", g.row), 16'(cnt_s), 16'(g.xcnts));
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; valid = 1'b0; rs = '0; rt = '0;
    urs = 1'b0; urt = 1'b0; uimm = 1'b0; exrd = '0; exwe = 1'b0;
    exld = 1'b0; memrd = '0; memwe = 1'b0;

    //     rst h v  rs rt urs urt imm exrd we ld memrd mw  stall bub sa sb cnt cnts
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
    addVec(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
    addVec(0, 0, 1, 5, 5, 1, 1, 0, 5, 1, 0, 0, 0,   0, 0, 1, 1, 0, 0);
    addVec(0, 0, 1, 5, 5, 1, 1, 0, 5, 1, 0, 5, 1,   0, 0, 1, 1, 0, 0);
    addVec(0, 0, 1, 5, 5, 1, 1, 0, 3, 1, 0, 5, 1,   0, 0, 2, 2, 0, 0);
    addVec(0, 0, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    addVec(0, 0, 1, 9, 4, 1, 0, 1, 4, 1, 0, 0, 0,   0, 0, 0, 3, 0, 0);
    addVec(0, 0, 1, 4, 4, 0, 1, 0, 4, 1, 0, 0, 0,   0, 0, 0, 1, 0, 0);
    addVec(0, 0, 0, 1, 2, 1, 1, 0, 3, 0, 0, 0, 0,   0, 1, 0, 0, 0, 0);
    addVec(0, 0, 1, 7, 2, 1, 1, 0, 7, 1, 1, 0, 0,   1, 1, 0, 0, 1, 1);
    addVec(0, 0, 1, 7, 2, 1, 1, 0, 0, 0, 0, 7, 1,   0, 0, 2, 0, 1, 1);
    addVec(0, 0, 1, 1, 8, 1, 1, 1, 8, 1, 1, 0, 0,   0, 0, 0, 3, 1, 1);
    addVec(0, 0, 0, 8, 0, 1, 0, 0, 8, 1, 1, 0, 0,   0, 1, 1, 0, 1, 1);
    addVec(0, 0, 1, 6, 6, 1, 1, 0, 6, 1, 0, 0, 0,   0, 0, 1, 1, 1, 1);
    for (int k = 0; k < 3; k++)
      addVec(0, 1, 1, 2, 2, 1, 1, 0, 0, 0, 0, 2, 1, 1, 0, 1, 1, 1, 1);
    addVec(0, 1, 1, 7, 0, 1, 0, 0, 7, 1, 1, 0, 0,   1, 0, 1, 1, 1, 1);
    addVec(0, 0, 1, 7, 0, 1, 0, 0, 7, 1, 1, 0, 0,   1, 1, 0, 0, 2, 2);
    addVec(0, 1, 1, 7, 0, 1, 0, 0, 0, 0, 0, 7, 1,   0, 1, 0, 0, 2, 2);
    addVec(0, 0, 1, 7, 0, 1, 0, 0, 0, 0, 0, 7, 1,   0, 0, 2, 0, 2, 2);
    addVec(0, 0, 1, 7, 0, 1, 0, 0, 7, 1, 1, 0, 0,   1, 1, 0, 0, 3, 3);
    addVec(1, 0, 1, 7, 0, 1, 0, 0, 7, 1, 1, 0, 0,   0, 1, 0, 0, 0, 0);
    addVec(0, 0, 1, 7, 0, 1, 0, 0, 7, 1, 1, 0, 0,   1, 1, 0, 0, 1, 1);
    addVec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 1, 1);

    // Five back-to-back load-use events: wide counter keeps going, 2-bit one pins at 3
    for (int k = 1; k <= 5; k++) begin
      addVec(0, 0, 1, 7, 0, 1, 0, 0, 7, 1, 1, 0, 0, 1, 1, 0, 0,
             16'(1 + k), (k >= 2) ? 2'd3 : 2'd2);
      addVec(0, 0, 1, 7, 0, 1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 2, 0,
             16'(1 + k), (k >= 2) ? 2'd3 : 2'd2);
    end

    foreach (vecs[i]) applyStimulus(vecs[i], i);

    checkOutput("scoreboard_drained", 16'(sb.size()), 16'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fwd_sel_ctrl.md
Name: fwd_sel_ctrl

Overview:
- Control block that produces the 2-bit `code` selects for the two EX-stage 32-bit 4:1 operand muxes: ALU operand A and ALU operand B.
- Sits in the ID stage.
- Compares the decoding instruction's source registers against the destinations of the instructions in EX and MEM.
- Registers the resulting select codes into the ID/EX boundary.
- Detects load-use hazards, issues a one-cycle stall plus a bubble, and honours an external pipeline hold.

Parameters:
- REG_AW, 5, register-address width.
- CNT_W, 16, width of the saturating stall-event counter.

Ports:
- clk  in  1  single clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- hold_i  in  1  external pipeline freeze (e.g. memory wait)
- id_valid_i  in  1  ID holds a real instruction
- id_rs_i  in  REG_AW  source reg A
- id_rt_i  in  REG_AW  source reg B
- id_use_rs_i  in  1  instruction reads rs
- id_use_rt_i  in  1  instruction reads rt as operand B
- id_use_imm_i  in  1  operand B is the immediate
- ex_rd_i  in  REG_AW  destination of instruction currently in EX
- ex_we_i  in  1  EX instruction writes the register file
- ex_load_i  in  1  EX instruction is a load
- mem_rd_i  in  REG_AW  destination of instruction in MEM
- mem_we_i  in  1  MEM instruction writes the register file
- stall_o  out  1  freeze PC and IF/ID this cycle (combinational)
- bubble_o  out  1  registered: ID/EX holds a NOP
- sel_a_o  out  2  registered operand-A mux code
- sel_b_o  out  2  registered operand-B mux code
- stall_cnt_o  out  CNT_W  load-use stall events, saturating

Behaviour:
- Mux code encoding, fixed: 0 = regfile read, 1 = EX/MEM ALU result, 2 = MEM/WB result, 3 = immediate. Code 3 is used on B only; sel_a_o never equals 3.
- Reset, when rst=1 at posedge:
  - sel_a_o = 0, sel_b_o = 0
  - bubble_o = 1
  - stall_cnt_o = 0
  - state = RUN
  - stall_o is 0 while rst=1
- Match rules, evaluated combinationally in ID:
  - hitEX(r) = ex_we_i & (ex_rd_i == r) & (r != 0)
  - hitMEM(r) = mem_we_i & (mem_rd_i == r) & (r != 0)
  - Register 0 never forwards.
- Select computation:
  - selA = hitEX(rs) ? 1 : hitMEM(rs) ? 2 : 0. The EX match wins when both match (youngest producer).
  - selB = id_use_imm_i ? 3 : hitEX(rt) ? 1 : hitMEM(rt) ? 2 : 0.
  - An operand whose use bit is 0 gets code 0.
- Load-use hazard:
  - lu = id_valid_i & ex_load_i & ((id_use_rs_i & hitEX(rs)) | (id_use_rt_i & ~id_use_imm_i & hitEX(rt))).
- FSM, states RUN, LU_STALL, HOLD:
  - **RUN**:
    - hold_i=1 → HOLD, stall_o=1, registered outputs keep their values.
    - else lu=1 → LU_STALL, stall_o=1; next cycle bubble_o=1 and sel codes = 0; stall_cnt_o increments, saturating at all-ones.
    - else → stall_o=0; next cycle bubble_o = ~id_valid_i, sel_a_o = selA, sel_b_o = selB.
  - **LU_STALL**:
    - Lasts exactly one cycle and does not re-detect lu: the load has moved to MEM, so the recomputed select yields 2.
    - hold_i=1 → HOLD.
    - else → RUN with the same load as RUN's no-hazard branch.
    - stall_o=0.
  - **HOLD**:
    - stall_o=1; all registers frozen, counter included.
    - Leave to RUN on the first cycle with hold_i=0; decisions resume that cycle as in RUN.
- Simultaneous hold_i and lu: hold takes priority. lu is re-evaluated after hold releases and is counted only then.
- Reset mid-stall or mid-hold: returns to RUN with reset values. No pending stall survives.
- Latency: select codes appear one clock after ID presents the instruction, aligned with its entry into EX.

Decomposition:
- Shared package `pipe_pkg`:
  - SEL_RF=0, SEL_EXMEM=1, SEL_MEMWB=2, SEL_IMM=3
  - the FSM state encoding
  - REG_AW default
- One natural sub-module, `fwd_match`: combinational. Takes one source reg plus the EX/MEM dest/we and returns the hitEX/hitMEM pair. Instantiated twice, for rs and rt.

Test Plan:
- Reset: assert rst 2 cycles → sel_a_o=0, sel_b_o=0, bubble_o=1, stall_o=0, stall_cnt_o=0.
- ALU back-to-back: ex_rd=5, ex_we=1, ex_load=0; ID rs=5, rt=5 → next cycle sel_a=1, sel_b=1, stall_o=0. With mem_rd=5 also set → still 1 (EX wins).
- r0 and immediate: ex_rd=0, ex_we=1, rs=0 → sel_a=0. Set id_use_imm=1 with rt matching EX → sel_b=3.
- Load-use: ex_load=1, ex_rd=7, rs=7 → stall_o=1 one cycle, then bubble_o=1, counter=1. Next cycle (mem_rd=7, mem_we=1, EX bubble) → sel_a=2, no second stall.
- Hold: hold_i high 3 cycles during a forwarded op → stall_o=1 each cycle, sel/bubble/counter unchanged. Hold plus lu together → counter increments only after release.
- Saturation: CNT_W=2, 5 load-use events → stall_cnt_o stops at 3.
